// File: rtl/lcd_800_480_timing.sv
`timescale 1ns / 1ps
// Video timing generator for the 800x480 parallel RGB LCD: holds the panel idle until
// PLL lock has settled, then produces registered, mutually aligned sync/enable/coordinates.
module lcd_800_480_timing #(
    parameter int H_ACTIVE        = 800,
    parameter int H_FRONT         = 40,
    parameter int H_SYNC          = 48,
    parameter int H_BACK          = 40,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 13,
    parameter int V_SYNC          = 3,
    parameter int V_BACK          = 29,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_SETTLE     = 1024,
    parameter int X_WIDTH         = 10,
    parameter int Y_WIDTH         = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               frame_start,
    output logic               running
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int CNT_W   = $clog2(LOCK_SETTLE + 1);

    localparam logic [X_WIDTH-1:0] H_LAST   = X_WIDTH'(H_TOTAL - 1);
    localparam logic [X_WIDTH-1:0] H_DE_END = X_WIDTH'(H_ACTIVE);
    localparam logic [X_WIDTH-1:0] HS_BEGIN = X_WIDTH'(H_ACTIVE + H_FRONT);
    localparam logic [X_WIDTH-1:0] HS_END   = X_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [Y_WIDTH-1:0] V_LAST   = Y_WIDTH'(V_TOTAL - 1);
    localparam logic [Y_WIDTH-1:0] V_DE_END = Y_WIDTH'(V_ACTIVE);
    localparam logic [Y_WIDTH-1:0] VS_BEGIN = Y_WIDTH'(V_ACTIVE + V_FRONT);
    localparam logic [Y_WIDTH-1:0] VS_END   = Y_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic               SYNC_IDLE   = (SYNC_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(LOCK_SETTLE - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

    logic               sync1_q, lock_s_q;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               display_on_q, display_on_d;
    logic               frame_start_q, frame_start_d;
    logic               running_q, running_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        settle_d  = settle_q;
        x_d       = '0;
        y_d       = '0;
        running_d = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                settle_d = '0;
                if (lock_s_q) state_d = SETTLE;
            end
            SETTLE: begin
                if (!lock_s_q) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d   = RUN;
                    settle_d  = '0;
                    running_d = 1'b1;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else begin
                    running_d = 1'b1;
                    if (x_q == H_LAST) begin
                        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                        y_d = y_q;
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        // Decode from the next coordinates so every registered output describes the same pixel.
        display_on_d  = running_d && (x_d < H_DE_END) && (y_d < V_DE_END);
        hsync_d       = (running_d && (x_d >= HS_BEGIN) && (x_d < HS_END)) ? ~SYNC_IDLE : SYNC_IDLE;
        vsync_d       = (running_d && (y_d >= VS_BEGIN) && (y_d < VS_END)) ? ~SYNC_IDLE : SYNC_IDLE;
        frame_start_d = running_d && (x_d == '0) && (y_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            lock_s_q      <= 1'b0;
            state_q       <= WAIT_LOCK;
            settle_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            display_on_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            sync1_q       <= pll_lock;
            lock_s_q      <= sync1_q;
            state_q       <= state_d;
            settle_q      <= settle_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

endmodule

// File: tb/tb_lcd_800_480_timing.sv
`timescale 1ns / 1ps
// Self-checking bench: a reduced-size active-low instance and an active-high, zero-front-porch
// instance run in lockstep against a lock-streak reference model through per-cycle scoreboards.
module tb_lcd_800_480_timing;
    localparam int HA = 16, HF = 4, HS = 5, HB = 3;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2;
    localparam int LS = 20;
    localparam int HT = HA + HF + HS + HB;
    localparam int HT_B = HA + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic       run;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic pll_lock;

    logic hsync_a, vsync_a, display_on_a, frame_start_a, running_a;
    logic [9:0] x_a, y_a;
    logic hsync_b, vsync_b, display_on_b, frame_start_b, running_b;
    logic [9:0] x_b, y_b;

    always #5 clk = ~clk;

    lcd_800_480_timing #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1), .LOCK_SETTLE(LS), .X_WIDTH(10), .Y_WIDTH(10)
    ) dut_a (
        .clk(clk), .rst(rst), .pll_lock(pll_lock),
        .hsync(hsync_a), .vsync(vsync_a), .display_on(display_on_a),
        .x(x_a), .y(y_a), .frame_start(frame_start_a), .running(running_a)
    );

    lcd_800_480_timing #(
        .H_ACTIVE(HA), .H_FRONT(0), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(0), .LOCK_SETTLE(LS), .X_WIDTH(10), .Y_WIDTH(10)
    ) dut_b (
        .clk(clk), .rst(rst), .pll_lock(pll_lock),
        .hsync(hsync_b), .vsync(vsync_b), .display_on(display_on_b),
        .x(x_b), .y(y_b), .frame_start(frame_start_b), .running(running_b)
    );

    obs_t obs_a, obs_b;
    assign obs_a = {hsync_a, vsync_a, display_on_a, frame_start_a, running_a, x_a, y_a};
    assign obs_b = {hsync_b, vsync_b, display_on_b, frame_start_b, running_b, x_b, y_b};

    obs_t exp_a_q[$];
    obs_t exp_b_q[$];
    obs_t last_exp_a;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Reference model state: the two synchronizer stages and the run of consecutive
    // synchronized-high cycles; the panel runs once that run exceeds LS.
    bit m_s1, m_ls;
    int streak;

    bit seen_run, fs_valid;
    int last_fs, de_count;

    function automatic obs_t model(input int t, input bit run, input int hf, input int ht,
                                   input bit act_low);
        obs_t o;
        int   xi, yi;
        o.hs = act_low; o.vs = act_low; o.de = 1'b0; o.fs = 1'b0; o.run = 1'b0;
        o.x  = '0; o.y = '0;
        if (run) begin
            xi    = t % ht;
            yi    = (t / ht) % VT;
            o.run = 1'b1;
            o.x   = 10'(xi);
            o.y   = 10'(yi);
            o.de  = (xi < HA) && (yi < VA);
            o.fs  = (xi == 0) && (yi == 0);
            if (xi >= HA + hf && xi < HA + hf + HS) o.hs = !act_low;
            if (yi >= VA + VF && yi < VA + VF + VS) o.vs = !act_low;
        end
        return o;
    endfunction

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got hs=%b vs=%b de=%b fs=%b run=%b x=%0d y=%0d, expected hs=%b vs=%b de=%b fs=%b run=%b x=%0d y=%0d",
                   tag, cycle, got.hs, got.vs, got.de, got.fs, got.run, got.x, got.y,
                   exp.hs, exp.vs, exp.de, exp.fs, exp.run, exp.x, exp.y);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got %0d, expected %0d", tag, cycle, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1     = 1'b0;
        m_ls     = 1'b0;
        streak   = 0;
        cycle    = 0;
        seen_run = 1'b0;
        fs_valid = 1'b0;
        de_count = 0;
    endtask

    task automatic check_idle(input string tag);
        exp_a_q.push_back(model(0, 1'b0, HF, HT, 1'b1));
        exp_b_q.push_back(model(0, 1'b0, 0, HT_B, 1'b0));
        check_obs({tag, "_a"}, obs_a, exp_a_q.pop_front());
        check_obs({tag, "_b"}, obs_b, exp_b_q.pop_front());
    endtask

    // One clock: drive pll_lock, predict the outputs after the coming edge, then compare.
    task automatic step(input logic lock);
        int  streak_n;
        bit  run;
        pll_lock = lock;
        streak_n = m_ls ? streak + 1 : 0;
        m_ls     = m_s1;
        m_s1     = lock;
        streak   = streak_n;
        run      = (streak >= LS + 1);
        last_exp_a = model(streak - (LS + 1), run, HF, HT, 1'b1);
        exp_a_q.push_back(last_exp_a);
        exp_b_q.push_back(model(streak - (LS + 1), run, 0, HT_B, 1'b0));
        @(posedge clk);
        #1;
        cycle++;
        check_obs("a", obs_a, exp_a_q.pop_front());
        check_obs("b", obs_b, exp_b_q.pop_front());

        if (running_a && !seen_run) begin
            seen_run = 1'b1;
            check_int("first_run_latency", cycle, LS + 3);
        end
        if (frame_start_a) begin
            if (fs_valid) begin
                check_int("frame_period", cycle - last_fs, HT * VT);
                check_int("de_per_frame", de_count, HA * VA);
            end
            fs_valid = 1'b1;
            last_fs  = cycle;
            de_count = 0;
        end
        if (display_on_a) de_count++;
        if (!running_a) fs_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rst      = 1'b1;
        pll_lock = 1'b1;
        model_reset();
        #12;
        check_idle("reset");
        #1 rst = 1'b0;

        // Lock present from release: settle, then two full frames.
        for (int i = 0; i < LS + 3 + 2 * HT * VT + 5; i++) step(1'b1);

        // Lose lock, relock, then a one-clock glitch partway through settling.
        for (int i = 0; i < 4; i++) step(1'b0);
        for (int i = 0; i < 3 + LS / 2; i++) step(1'b1);
        step(1'b0);
        for (int i = 0; i < LS + 10; i++) step(1'b1);

        // Drop lock mid-frame at a known pixel, then relock and restart from the origin.
        hit = 1'b0;
        for (int i = 0; i < HT * VT + 5 && !hit; i++) begin
            step(1'b1);
            hit = last_exp_a.run && last_exp_a.x == 10'd10 && last_exp_a.y == 10'd3;
        end
        for (int i = 0; i < 5; i++) step(1'b0);
        for (int i = 0; i < LS + 3 + 40; i++) step(1'b1);

        // Asynchronous reset between edges, mid-line.
        hit = 1'b0;
        for (int i = 0; i < HT + 2 && !hit; i++) begin
            step(1'b1);
            hit = last_exp_a.run && last_exp_a.x == 10'd5;
        end
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_idle("async_rst");
        #1 rst = 1'b0;
        for (int i = 0; i < LS + 3 + 40; i++) step(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
